// File: rtl/wt_dcache_nru_ctrl.sv
// NRU replacement-state update sequencer: one array update per cycle chosen from
// miss allocations, buffered read-port hit hints, or a full-array flush sweep.
module wt_dcache_nru_ctrl #(
    parameter int unsigned NUM_RD_PORTS = 3,
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned WAY_W        = 2,
    parameter int unsigned NUM_SETS     = 256,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    output logic                          flush_ack_o,
    input  logic [NUM_RD_PORTS-1:0]       rd_hit_i,
    input  logic [NUM_RD_PORTS*IDX_W-1:0] rd_hit_idx_i,
    input  logic [NUM_RD_PORTS*WAY_W-1:0] rd_hit_way_i,
    input  logic                          miss_req_i,
    input  logic [IDX_W-1:0]              miss_idx_i,
    output logic                          miss_gnt_o,
    output logic                          upd_hit_o,
    output logic [IDX_W-1:0]              upd_hit_idx_o,
    output logic [WAY_W-1:0]              upd_hit_way_o,
    output logic                          upd_miss_o,
    output logic [IDX_W-1:0]              upd_miss_idx_o,
    output logic                          upd_clr_o,
    output logic [IDX_W-1:0]              upd_clr_idx_o,
    output logic                          busy_o,
    output logic                          hit_drop_o,
    output logic [15:0]                   drop_cnt_o
);

    localparam int unsigned RR_W  = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]             state;
    logic [IDX_W-1:0]       sweep;
    logic [RR_W-1:0]        rr;
    logic [IDX_W+WAY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [15:0]            drop_cnt;
    logic                   flush_ack;

    logic                    idle;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push;
    logic                    found;
    logic                    drop;
    logic                    sweep_last;
    logic [RR_W-1:0]         win;
    logic [NUM_RD_PORTS-1:0] win_mask;
    logic [NUM_RD_PORTS-1:0] gnt_mask;
    logic [IDX_W-1:0]        push_idx;
    logic [WAY_W-1:0]        push_way;
    logic [IDX_W+WAY_W-1:0]  head;

    assign idle       = (state == IDLE);
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign sweep_last = (sweep == IDX_W'(NUM_SETS - 1));
    assign head       = mem[rd_ptr];

    // Rotating priority: ports at or above rr first, then the wrapped-around ones.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_mask = '0;
        push_idx = '0;
        push_way = '0;
        for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
            if (!found && rd_hit_i[k] && (k >= 32'(rr))) begin
                found       = 1'b1;
                win         = RR_W'(k);
                win_mask[k] = 1'b1;
                push_idx    = rd_hit_idx_i[k*IDX_W +: IDX_W];
                push_way    = rd_hit_way_i[k*WAY_W +: WAY_W];
            end
        end
        for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
            if (!found && rd_hit_i[k] && (k < 32'(rr))) begin
                found       = 1'b1;
                win         = RR_W'(k);
                win_mask[k] = 1'b1;
                push_idx    = rd_hit_idx_i[k*IDX_W +: IDX_W];
                push_way    = rd_hit_way_i[k*WAY_W +: WAY_W];
            end
        end
    end

    assign push     = idle && found && !full;
    assign gnt_mask = push ? win_mask : '0;
    assign drop     = idle && |(rd_hit_i & ~gnt_mask);
    assign pop      = idle && !miss_req_i && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            sweep     <= '0;
            flush_ack <= 1'b0;
        end else begin
            flush_ack <= 1'b0;
            if (idle) begin
                if (flush_i) begin
                    state <= FLUSH;
                    sweep <= '0;
                end
            end else if (sweep_last) begin
                state     <= IDLE;
                sweep     <= '0;
                flush_ack <= 1'b1;
            end else begin
                sweep <= sweep + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rr       <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                rr <= (win == RR_W'(NUM_RD_PORTS - 1)) ? '0 : win + 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (idle && flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {push_idx, push_way};
        end
    end

    assign flush_ack_o    = flush_ack;
    assign busy_o         = !idle;
    assign miss_gnt_o     = idle && miss_req_i;
    assign upd_miss_o     = idle && miss_req_i;
    assign upd_miss_idx_o = (idle && miss_req_i) ? miss_idx_i : '0;
    assign upd_hit_o      = pop;
    assign upd_hit_idx_o  = pop ? head[WAY_W +: IDX_W] : '0;
    assign upd_hit_way_o  = pop ? head[WAY_W-1:0] : '0;
    assign upd_clr_o      = !idle;
    assign upd_clr_idx_o  = idle ? '0 : sweep;
    assign hit_drop_o     = drop;
    assign drop_cnt_o     = drop_cnt;

endmodule

// File: tb/tb_wt_dcache_nru_ctrl.sv
// Scoreboard bench for wt_dcache_nru_ctrl: a queue-based reference model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_wt_dcache_nru_ctrl;

    localparam int NP = 3;
    localparam int IW = 8;
    localparam int WW = 2;
    localparam int NS = 256;
    localparam int FD = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            flush_ack_o;
    logic [NP-1:0]   rd_hit_i = '0;
    logic [NP*IW-1:0] rd_hit_idx_i = '0;
    logic [NP*WW-1:0] rd_hit_way_i = '0;
    logic            miss_req_i = 1'b0;
    logic [IW-1:0]   miss_idx_i = '0;
    logic            miss_gnt_o;
    logic            upd_hit_o;
    logic [IW-1:0]   upd_hit_idx_o;
    logic [WW-1:0]   upd_hit_way_o;
    logic            upd_miss_o;
    logic [IW-1:0]   upd_miss_idx_o;
    logic            upd_clr_o;
    logic [IW-1:0]   upd_clr_idx_o;
    logic            busy_o;
    logic            hit_drop_o;
    logic [15:0]     drop_cnt_o;

    wt_dcache_nru_ctrl #(
        .NUM_RD_PORTS(NP), .IDX_W(IW), .WAY_W(WW), .NUM_SETS(NS), .FIFO_DEPTH(FD)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
        .rd_hit_i(rd_hit_i), .rd_hit_idx_i(rd_hit_idx_i), .rd_hit_way_i(rd_hit_way_i),
        .miss_req_i(miss_req_i), .miss_idx_i(miss_idx_i), .miss_gnt_o(miss_gnt_o),
        .upd_hit_o(upd_hit_o), .upd_hit_idx_o(upd_hit_idx_o), .upd_hit_way_o(upd_hit_way_o),
        .upd_miss_o(upd_miss_o), .upd_miss_idx_o(upd_miss_idx_o),
        .upd_clr_o(upd_clr_o), .upd_clr_idx_o(upd_clr_idx_o),
        .busy_o(busy_o), .hit_drop_o(hit_drop_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        hit;
        logic        miss;
        logic        clr;
        logic        gnt;
        logic        drop;
        logic        busy;
        logic        ack;
        logic [7:0]  hidx;
        logic [1:0]  hway;
        logic [7:0]  midx;
        logic [7:0]  cidx;
        logic [15:0] dc;
    } obs_t;

    typedef struct {
        int idx;
        int way;
    } hint_t;

    obs_t  exp_q[$];
    hint_t mq[$];
    int    m_rr = 0;
    int    m_sweep = 0;
    int    m_dc = 0;
    bit    m_flushing = 1'b0;
    bit    m_ack = 1'b0;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    bit    chk_en = 1'b0;
    obs_t  mon_a;
    obs_t  mon_e;

    // Index fields are only meaningful while their update strobe is high.
    function automatic obs_t observe();
        obs_t o;
        o      = '0;
        o.hit  = upd_hit_o;
        o.miss = upd_miss_o;
        o.clr  = upd_clr_o;
        o.gnt  = miss_gnt_o;
        o.drop = hit_drop_o;
        o.busy = busy_o;
        o.ack  = flush_ack_o;
        o.hidx = upd_hit_o ? upd_hit_idx_o : '0;
        o.hway = upd_hit_o ? upd_hit_way_o : '0;
        o.midx = upd_miss_o ? upd_miss_idx_o : '0;
        o.cidx = upd_clr_o ? upd_clr_idx_o : '0;
        o.dc   = drop_cnt_o;
        return o;
    endfunction

    always @(negedge clk_i) begin
        if (rst_ni && chk_en) begin
            cyc++;
            mon_a = observe();
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty cycle=%0d act=%h req=<none>", cyc, mon_a);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    miscompares++;
                    $display("FAIL cycle_outputs cycle=%0d act=%h req=%h", cyc, mon_a, mon_e);
                end
            end
        end
    end

    // Drive one cycle of inputs, predict that cycle's outputs, advance the model past the edge.
    task automatic step(input bit fl, input logic [NP-1:0] h, input logic [NP*IW-1:0] hi,
                        input logic [NP*WW-1:0] hw, input bit mr, input logic [IW-1:0] mi);
        obs_t e;
        int   occ;
        int   win;
        int   nvalid;
        int   p;
        hint_t nh;
        flush_i      = fl;
        rd_hit_i     = h;
        rd_hit_idx_i = hi;
        rd_hit_way_i = hw;
        miss_req_i   = mr;
        miss_idx_i   = mi;
        e      = '0;
        e.dc   = 16'(m_dc);
        e.ack  = m_ack;
        m_ack  = 1'b0;
        if (m_flushing) begin
            e.clr  = 1'b1;
            e.busy = 1'b1;
            e.cidx = 8'(m_sweep);
            if (m_sweep == NS - 1) begin
                m_flushing = 1'b0;
                m_sweep    = 0;
                m_ack      = 1'b1;
            end else begin
                m_sweep++;
            end
        end else begin
            occ = mq.size();
            if (mr) begin
                e.miss = 1'b1;
                e.gnt  = 1'b1;
                e.midx = mi;
            end else if (occ > 0) begin
                e.hit  = 1'b1;
                e.hidx = 8'(mq[0].idx);
                e.hway = 2'(mq[0].way);
                void'(mq.pop_front());
            end
            win    = -1;
            nvalid = 0;
            for (int d = 0; d < NP; d++) begin
                p = (m_rr + d) % NP;
                if (h[p]) begin
                    nvalid++;
                    if (win < 0) win = p;
                end
            end
            if (occ >= FD) win = -1;
            if (win >= 0) begin
                nh.idx = int'(hi[win*IW +: IW]);
                nh.way = int'(hw[win*WW +: WW]);
                mq.push_back(nh);
                m_rr = (win + 1) % NP;
            end
            if (nvalid > ((win >= 0) ? 1 : 0)) begin
                e.drop = 1'b1;
                if (m_dc < 65535) m_dc++;
            end
            if (fl) begin
                mq.delete();
                m_flushing = 1'b1;
                m_sweep    = 0;
            end
        end
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic check_all_zero(input string name);
        logic [63:0] raw;
        raw = {15'd0, flush_ack_o, miss_gnt_o, upd_hit_o, upd_hit_idx_o, upd_hit_way_o,
               upd_miss_o, upd_miss_idx_o, upd_clr_o, upd_clr_idx_o, busy_o, hit_drop_o, drop_cnt_o};
        vectors++;
        if (raw !== 64'd0) begin
            miscompares++;
            $display("FAIL %s act=%h req=0", name, raw);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP*IW-1:0] ri;
        logic [NP*WW-1:0] rw;

        #12;
        check_all_zero("reset_outputs");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // Round-robin: all three ports valid for three cycles from rr=0.
        for (int i = 0; i < 3; i++) step(1'b0, 3'b111, {8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)}, 6'b10_01_11, 1'b0, '0);
        idle_cycles(4);

        // Single hint on port 0.
        step(1'b0, 3'b001, {8'h00, 8'h00, 8'h12}, 6'b00_00_10, 1'b0, '0);
        idle_cycles(2);

        // Fill the FIFO behind a miss, then two more hints that must be dropped.
        for (int i = 0; i < 4; i++) step(1'b0, 3'b010, {8'h00, 8'h40 + 8'(i), 8'h00}, {2'b00, 2'(i), 2'b00}, 1'b1, 8'h80 + 8'(i));
        for (int i = 0; i < 2; i++) step(1'b0, 3'b100, {8'h55, 8'h00, 8'h00}, 6'b11_00_00, 1'b1, 8'hA0 + 8'(i));
        idle_cycles(6);

        // Flush with two entries queued and miss requests pressing during the sweep.
        for (int i = 0; i < 2; i++) step(1'b0, 3'b001, {8'h00, 8'h00, 8'h60 + 8'(i)}, 6'b00_00_01, 1'b1, 8'h11);
        step(1'b1, 3'b000, '0, '0, 1'b0, '0);
        for (int i = 0; i < NS + 4; i++) begin
            ri = {8'($urandom), 8'($urandom), 8'($urandom)};
            rw = 6'($urandom);
            step(1'b0, 3'($urandom), ri, rw, 1'($urandom), 8'($urandom));
        end

        // Random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            ri = {8'($urandom), 8'($urandom), 8'($urandom)};
            rw = 6'($urandom);
            step(($urandom_range(0, 199) == 0), 3'($urandom), ri, rw,
                 ($urandom_range(0, 9) < 3), 8'($urandom));
        end
        while (m_flushing) idle_cycles(1);
        idle_cycles(2);

        // Drop counter saturation.
        for (int i = 0; i < 65540; i++) begin
            ri = {8'($urandom), 8'($urandom), 8'($urandom)};
            step(1'b0, 3'b111, ri, 6'($urandom), 1'b1, 8'($urandom));
        end
        idle_cycles(6);

        // Reset in the middle of a sweep, then a fresh full sweep.
        step(1'b1, 3'b000, '0, '0, 1'b0, '0);
        while (!(m_flushing && m_sweep == 100)) step(1'b0, 3'($urandom), '0, '0, 1'b0, '0);
        flush_i    = 1'b0;
        rd_hit_i   = '0;
        miss_req_i = 1'b0;
        rst_ni     = 1'b0;
        #1;
        check_all_zero("reset_mid_flush");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        mq.delete();
        m_rr       = 0;
        m_sweep    = 0;
        m_dc       = 0;
        m_flushing = 1'b0;
        m_ack      = 1'b0;
        rst_ni     = 1'b1;
        step(1'b1, 3'b000, '0, '0, 1'b0, '0);
        idle_cycles(NS + 3);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover act=%0d req=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wt_dcache_nru_ctrl.md
Name: wt_dcache_nru_ctrl

Overview:
- Sequences every update of the dcache NRU replacement-state array through a single update port per cycle.
- Arbitrates three sources: round-robin among read-port hit hints, which are buffered in a small FIFO; miss allocations, which have priority; and a multi-cycle flush sweep that walks every set.
- Sits between the dcache read ports / miss unit and the NRU state array.

Parameters:
- NUM_RD_PORTS, 3, number of dcache read ports issuing hit hints.
- IDX_W, 8, set index width (DCACHE_CL_IDX_WIDTH).
- WAY_W, 2, way index width (4-way).
- NUM_SETS, 256, number of sets swept by a flush (2**IDX_W).
- FIFO_DEPTH, 4, hit-hint FIFO entries (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  flush request, level; sampled in IDLE only.
- flush_ack_o  out  1  one-cycle pulse when the sweep completes.
- rd_hit_i  in  NUM_RD_PORTS  per-port hit hint valid.
- rd_hit_idx_i  in  NUM_RD_PORTS*IDX_W  per-port hit set index, port p at [p*IDX_W +: IDX_W].
- rd_hit_way_i  in  NUM_RD_PORTS*WAY_W  per-port hit way.
- miss_req_i  in  1  miss unit requests allocation update.
- miss_idx_i  in  IDX_W  set of the miss.
- miss_gnt_o  out  1  miss update issued this cycle (combinational).
- upd_hit_o  out  1  array: mark hit way used.
- upd_hit_idx_o  out  IDX_W  set for upd_hit_o.
- upd_hit_way_o  out  WAY_W  way for upd_hit_o.
- upd_miss_o  out  1  array: perform victim select/allocate.
- upd_miss_idx_o  out  IDX_W  set for upd_miss_o.
- upd_clr_o  out  1  array: reset the set's NRU bits to all-ones.
- upd_clr_idx_o  out  IDX_W  set for upd_clr_o.
- busy_o  out  1  FSM in FLUSH.
- hit_drop_o  out  1  at least one valid hit hint was discarded this cycle.
- drop_cnt_o  out  16  saturating count of discarded-hint cycles.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; FIFO empty; rr pointer=0; sweep counter=0; drop_cnt=0.
- At most one of upd_hit_o, upd_miss_o, upd_clr_o is high in any cycle.
- FSM IDLE:
  - If flush_i=1 then next state is FLUSH. That cycle still issues a miss or hit update normally, and the FIFO is cleared at the clock edge.
  - Else if miss_req_i=1: miss_gnt_o=upd_miss_o=1, upd_miss_idx_o=miss_idx_i, FIFO not popped.
  - Else if the FIFO is non-empty: pop the head; upd_hit_o=1 with the head's idx/way.
- FSM FLUSH:
  - Each cycle: upd_clr_o=1, upd_clr_idx_o=counter, counter increments.
  - miss_gnt_o=0. All hit hints are discarded without counting as drops. flush_i is ignored.
  - When counter==NUM_SETS-1: counter wraps to 0, FSM returns to IDLE, flush_ack_o=1 on the next cycle (first IDLE cycle).
  - A sweep lasts exactly NUM_SETS cycles.
- Hit enqueue (IDLE only):
  - At most one hint is accepted per cycle.
  - The grant goes to the first valid port found scanning from rr upward, mod NUM_RD_PORTS.
  - A grant occurs only if the FIFO is not full. Full is based on the registered count; a pop in the same cycle does not free a slot.
  - On a grant to port k, rr <= (k+1) mod NUM_RD_PORTS. rr is unchanged otherwise.
  - An entry written at edge N is poppable from cycle N+1. Minimum hint-to-upd_hit_o latency is 1 cycle.
  - Push and pop in the same cycle are allowed; FIFO order is preserved.
- Drops:
  - hit_drop_o=1 when in IDLE and any rd_hit_i bit is not granted: losers of arbitration, or any hint while full.
  - drop_cnt_o increments by 1 per such cycle and saturates at 0xFFFF.
  - drop_cnt_o is cleared only by reset.
- Misses stall the FIFO indefinitely while miss_req_i stays high. No starvation guarantee for hints; they are lossy by design.
- Async reset mid-flush: immediate return to IDLE with counter 0. No flush_ack_o is produced for the aborted flush.

Test Plan:
- Single hint: rd_hit_i=001, idx=0x12, way=2 at cycle 0, FIFO empty -> cycle 1: upd_hit_o=1, idx 0x12, way 2; hit_drop_o=0.
- Round-robin: rd_hit_i=111 held 3 cycles with rr=0, miss_req_i=0 -> grants to ports 0,1,2 in order; hit_drop_o=1 each cycle; drop_cnt_o=3; upd_hit_o outputs match port order on cycles 1..3.
- Miss priority/full FIFO: FIFO holding 4 entries, miss_req_i=1 for 2 cycles plus a new hint each cycle -> miss_gnt_o=1 both cycles, no upd_hit_o, both hints dropped, drop_cnt_o +=2; pops resume after the miss deasserts, in original order.
- Flush: flush_i pulse with 2 entries queued -> FIFO cleared; upd_clr_o=1 with idx 0..255 on 256 consecutive cycles; miss_gnt_o=0 throughout; flush_ack_o one cycle after idx 255; busy_o high for exactly 256 cycles.
- Reset mid-flush: assert rst_ni=0 at sweep idx 100 -> outputs 0 immediately; after release a new flush starts at idx 0; flush_ack_o never pulses for the aborted sweep.
- Saturation: force 65540 drop cycles -> drop_cnt_o holds at 0xFFFF.
